// File: rtl/pp_gen_pipe.sv
// Baugh-Wooley partial-product generator, two-stage pipeline.
// Stage 1 holds an operand pair. Stage 2 holds the partial-product array,
// the exact signed product and the operand tag. The operands come either
// from the external port or from an internal exhaustive sweep counter.
// The compressor downstream adds the constants 2^DATA_W and 2^(2*DATA_W-1),
// so this block leaves them out of the array.
module pp_gen_pipe #(
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  input  logic                       sweep_start,
  output logic                       sweep_busy,
  output logic                       sweep_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W*DATA_W-1:0]   pp,
  output logic [2*DATA_W-1:0]        exact,
  output logic [2*DATA_W-1:0]        out_seq
);

  localparam int PP_W = DATA_W * DATA_W;
  localparam int P_W  = 2 * DATA_W;

  localparam logic ST_EXT   = 1'b0;
  localparam logic ST_SWEEP = 1'b1;

  // Baugh-Wooley array. Bit (DATA_W*i + j) has weight 2^(i+j), where row i
  // is a b bit and column j is an a bit. A term that pairs one sign bit
  // with one magnitude bit is complemented. The sign*sign term and the
  // magnitude*magnitude terms are left as they are.
  function automatic logic [PP_W-1:0] bw_pp(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [PP_W-1:0] r;
    logic            inv;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int j = 0; j < DATA_W; j++) begin
        inv = ((i == DATA_W - 1) != (j == DATA_W - 1));
        r[DATA_W*i + j] = (a[j] & b[i]) ^ inv;
      end
    end
    return r;
  endfunction

  // Full-width two's-complement product. Both operands are sign-extended
  // first, so the low P_W bits are exact.
  function automatic logic signed [P_W-1:0] smul(input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
    logic signed [P_W-1:0] ax;
    logic signed [P_W-1:0] bx;
    ax = {{DATA_W{a[DATA_W-1]}}, a};
    bx = {{DATA_W{b[DATA_W-1]}}, b};
    return ax * bx;
  endfunction

  // Control state
  logic                  state_q, state_d;
  logic [P_W-1:0]        cnt_q, cnt_d;
  logic                  vld_p1_q, vld_p1_d;
  logic                  vld_p2_q, vld_p2_d;

  // Datapath state
  logic signed [DATA_W-1:0] a_p1_q, a_p1_d;
  logic signed [DATA_W-1:0] b_p1_q, b_p1_d;
  logic [PP_W-1:0]          pp_p2_q, pp_p2_d;
  logic signed [P_W-1:0]    exact_p2_q, exact_p2_d;
  logic [P_W-1:0]           seq_p2_q, seq_p2_d;

  // Handshake terms
  logic                  in_sweep;
  logic                  src_valid;
  logic [DATA_W-1:0]     src_a;
  logic [DATA_W-1:0]     src_b;
  logic                  adv_p1;
  logic                  room_p1;
  logic                  load_p1;
  logic                  last_pair;

  // Select the operand source and work out the pipeline handshakes.
  always_comb begin
    in_sweep  = (state_q == ST_SWEEP);
    src_valid = in_sweep | in_valid;
    src_a     = in_sweep ? cnt_q[DATA_W-1:0]   : in_a;
    src_b     = in_sweep ? cnt_q[P_W-1:DATA_W] : in_b;
    // Stage 1 moves on when it is full and stage 2 either is empty or is
    // being drained this cycle.
    adv_p1    = vld_p1_q & (~vld_p2_q | out_ready);
    room_p1   = ~vld_p1_q | adv_p1;
    load_p1   = src_valid & room_p1;
    last_pair = in_sweep & (cnt_q == {P_W{1'b1}});
  end

  // Drive the externally visible control outputs.
  // in_ready and sweep_done are masked with rst: while reset is asserted
  // nothing is accepted and no sweep can finish.
  always_comb begin
    in_ready   = ~rst & ~in_sweep & room_p1;
    sweep_done = ~rst & load_p1 & last_pair;
    sweep_busy = in_sweep;
    out_valid  = vld_p2_q;
    pp         = pp_p2_q;
    exact      = exact_p2_q;
    out_seq    = seq_p2_q;
  end

  // Sweep FSM and its operand counter.
  // In SWEEP the counter is offered on every cycle and steps on each load.
  // Loading 0xFFFF ends the sweep and rewinds the counter for the next one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_EXT) begin
      if (sweep_start) begin
        state_d = ST_SWEEP;
      end
    end else if (load_p1) begin
      if (last_pair) begin
        state_d = ST_EXT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Occupancy flags for stages 1 and 2.
  always_comb begin
    vld_p1_d = vld_p1_q;
    if (load_p1) begin
      vld_p1_d = 1'b1;
    end else if (adv_p1) begin
      vld_p1_d = 1'b0;
    end
    vld_p2_d = vld_p2_q;
    if (adv_p1) begin
      vld_p2_d = 1'b1;
    end else if (out_ready) begin
      vld_p2_d = 1'b0;
    end
  end

  // Next values for stage 1 and stage 2 data.
  // Each stage keeps its value until it is loaded again, so the outputs
  // stay frozen while downstream stalls.
  always_comb begin
    a_p1_d     = a_p1_q;
    b_p1_d     = b_p1_q;
    pp_p2_d    = pp_p2_q;
    exact_p2_d = exact_p2_q;
    seq_p2_d   = seq_p2_q;
    if (load_p1) begin
      a_p1_d = src_a;
      b_p1_d = src_b;
    end
    if (adv_p1) begin
      pp_p2_d    = bw_pp(a_p1_q, b_p1_q);
      exact_p2_d = smul(a_p1_q, b_p1_q);
      seq_p2_d   = {b_p1_q, a_p1_q};
    end
  end

  // Control registers. Reset empties both stages, returns the FSM to EXT
  // and rewinds the sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EXT;
      cnt_q    <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- stage 1: operand register ----
  // Reset is not needed here: vld_p1_q qualifies the contents.
  always_ff @(posedge clk) begin
    a_p1_q <= a_p1_d;
    b_p1_q <= b_p1_d;
  end

  // ---- stage 2: partial products, exact product, operand tag ----
  // These registers drive the ports directly, so reset clears them to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pp_p2_q    <= '0;
      exact_p2_q <= '0;
      seq_p2_q   <= '0;
    end else begin
      pp_p2_q    <= pp_p2_d;
      exact_p2_q <= exact_p2_d;
      seq_p2_q   <= seq_p2_d;
    end
  end

endmodule

// File: tb/tb_pp_gen_pipe.sv
// Directed testbench for pp_gen_pipe: reset state, single products, stall
// behaviour, a full sweep, reset in the middle of a sweep, and random
// backpressure during a sweep.
module tb_pp_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sweep_done;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pp;
  logic [15:0] exact;
  logic [15:0] out_seq;

  pp_gen_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .sweep_start(sweep_start),
    .sweep_busy (sweep_busy),
    .sweep_done (sweep_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pp         (pp),
    .exact      (exact),
    .out_seq    (out_seq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Weighted sum of the array plus the two constants the compressor adds.
  function automatic logic [15:0] pp_sum(input logic [63:0] p);
    logic [15:0] s;
    s = 16'h8100;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (p[8*i + j]) s = s + (16'd1 << (i + j));
    return s;
  endfunction

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int pr;
    sa = $signed(a);
    sb = $signed(b);
    pr = sa * sb;
    return pr[15:0];
  endfunction

  // Offer one pair with out_ready high and check it two cycles later.
  task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ex);
    in_a = a; in_b = b; in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_exact"}, exact, ex);
    chk({tag, "_seq"}, out_seq, {b, a});
    chk({tag, "_ppsum"}, pp_sum(pp), ex);
    @(posedge clk); #1;
    chk({tag, "_drain"}, out_valid, 0);
  endtask

  logic [7:0]  ta [4];
  logic [7:0]  tbv[4];
  logic [15:0] gseq[4];
  logic [15:0] gex[4];
  logic [15:0] exp_seq;
  logic        acc;
  logic        found;
  int          idx, nout, err, busy_cnt, done_cnt, done_at, bad;

  initial begin
    ta  = '{8'h12, 8'h80, 8'hFF, 8'h55};
    tbv = '{8'h34, 8'h7F, 8'h01, 8'hAA};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    sweep_start = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pp", pp, 0);
    chk("rst_exact", exact, 0);
    chk("rst_seq", out_seq, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    single("p7f7f", 8'h7F, 8'h7F, 16'h3F01);
    single("p8080", 8'h80, 8'h80, 16'h4000);
    single("p8001", 8'h80, 8'h01, 16'hFF80);
    single("pffff", 8'hFF, 8'hFF, 16'h0001);

    // Four pairs back to back while the output is stalled for five cycles.
    idx = 0; nout = 0;
    for (int cyc = 0; cyc < 30 && nout < 4; cyc++) begin
      out_ready = (cyc >= 5);
      if (idx < 4) begin
        in_valid = 1'b1; in_a = ta[idx]; in_b = tbv[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_accepts", idx, 2);
      end
      if (cyc >= 2 && cyc <= 4) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_seq", out_seq, {tbv[0], ta[0]});
        chk("stall_exact", exact, ref_mul(ta[0], tbv[0]));
      end
      acc = in_valid & in_ready;
      if (out_valid & out_ready) begin
        gseq[nout] = out_seq; gex[nout] = exact; nout++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", nout, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stream_seq%0d", k), gseq[k], {tbv[k], ta[k]});
      chk($sformatf("stream_exact%0d", k), gex[k], ref_mul(ta[k], tbv[k]));
    end

    // Full sweep. An external pair offered on the start cycle must still go through.
    @(posedge clk); #1;
    in_a = 8'h03; in_b = 8'h05; in_valid = 1'b1; sweep_start = 1'b1;
    #1;
    chk("sw_start_in_ready", in_ready, 1);
    @(posedge clk); #1;
    sweep_start = 1'b0; in_a = 8'hAA; in_b = 8'hAA;
    chk("sw_busy", sweep_busy, 1);
    chk("sw_in_ready", in_ready, 0);
    nout = 0; busy_cnt = 0; done_cnt = 0; done_at = 0; err = 0; exp_seq = '0;
    for (int cyc = 0; cyc < 70000 && nout < 65537; cyc++) begin
      #1;
      if (sweep_busy) busy_cnt++;
      else in_valid = 1'b0;
      if (sweep_done) begin done_cnt++; done_at = busy_cnt; end
      if (out_valid) begin
        if (nout == 0) begin
          chk("sw_ext_seq", out_seq, 16'h0503);
          chk("sw_ext_exact", exact, 16'd15);
        end else begin
          if (out_seq !== exp_seq || exact !== ref_mul(exp_seq[7:0], exp_seq[15:8]) ||
              pp_sum(pp) !== exact) err++;
          exp_seq = exp_seq + 16'd1;
        end
        nout++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    chk("sw_out_count", nout, 65537);
    chk("sw_errors", err, 0);
    chk("sw_busy_cycles", busy_cnt, 65536);
    chk("sw_done_count", done_cnt, 1);
    chk("sw_done_at_last", done_at, 65536);
    chk("sw_end_busy", sweep_busy, 0);
    chk("sw_end_in_ready", in_ready, 1);

    // Reset in the middle of a sweep, while counter value 0x1234 is being loaded.
    @(posedge clk); #1;
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 6000 && !found; cyc++) begin
      #1;
      if (out_valid && out_seq == 16'h1232) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("mid_found", found, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_done", sweep_done, 0);
    @(posedge clk); #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy", sweep_busy, 0);
    chk("mid_exact", exact, 0);
    rst = 1'b0;
    bad = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (out_valid || sweep_done || sweep_busy) bad++;
      @(posedge clk); #1;
    end
    chk("mid_quiet_after", bad, 0);

    // Restarted sweep under random backpressure.
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    exp_seq = '0; nout = 0; err = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (sweep_done) done_cnt++;
      if (out_valid && out_ready) begin
        if (out_seq !== exp_seq || exact !== ref_mul(exp_seq[7:0], exp_seq[15:8]) ||
            pp_sum(pp) !== exact) err++;
        exp_seq = exp_seq + 16'd1;
        nout++;
      end
      @(posedge clk); #1;
    end
    chk("rnd_errors", err, 0);
    chk("rnd_progress", nout > 4000, 1);
    chk("rnd_no_done", done_cnt, 0);
    chk("rnd_busy", sweep_busy, 1);

    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("final_out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
